// File: rtl/iob_nco_multi_pkg.sv
// Shared constants and types for the multi-channel fractional-period NCO.
// Holds the config address map, the CTRL bit layout and the channel state encoding.
package iob_nco_multi_pkg;

  localparam logic [1:0] NCO_ADDR_PERIOD = 2'd0;
  localparam logic [1:0] NCO_ADDR_DUTY   = 2'd1;
  localparam logic [1:0] NCO_ADDR_BURST  = 2'd2;
  localparam logic [1:0] NCO_ADDR_CTRL   = 2'd3;

  localparam int NCO_CTRL_EN        = 0;
  localparam int NCO_CTRL_BURST     = 1;
  localparam int NCO_CTRL_WAIT_SYNC = 2;
  localparam int NCO_CTRL_W         = 3;

  typedef enum logic [1:0] {
    NCO_IDLE  = 2'd0,
    NCO_ARMED = 2'd1,
    NCO_RUN   = 2'd2
  } nco_state_e;

endpackage

// File: rtl/iob_nco_multi_ch.sv
// One NCO channel: shadow config registers, IDLE/ARMED/RUN control, fractional
// period accumulator with round-half-even quantisation, and the registered clock output.
module iob_nco_ch
  import iob_nco_multi_pkg::*;
#(
  parameter int INT_W   = 16,
  parameter int FRAC_W  = 16,
  parameter int BURST_W = 16
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [1:0]              wr_addr_i,
  input  logic [INT_W+FRAC_W-1:0] wr_data_i,
  input  logic                    start_i,
  output logic                    clk_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int PW = INT_W + FRAC_W;
  localparam int AW = PW + 1;
  localparam int QW = INT_W + 1;
  localparam logic [FRAC_W-1:0] FRAC_HALF = {1'b1, {(FRAC_W-1){1'b0}}};

  nco_state_e state, state_nxt;

  logic [PW-1:0]         per_sh, per_act;
  logic [INT_W-1:0]      duty_sh, duty_act;
  logic [BURST_W-1:0]    burst_sh, bcnt, burst_eff;
  logic [NCO_CTRL_W-1:0] ctrl, ctrl_cur;
  logic [AW-1:0]         acc, acc_nxt;
  logic [AW:0]           acc_sum, acc_dec;
  logic [QW-1:0]         acc_int, quant_rnd, quant, high_cnt, duty_ext, cnt;
  logic [FRAC_W-1:0]     acc_frac;
  logic                  wr_ctrl, boundary, burst_last, clk_int;
  logic                  run_load, done_nxt, clr_en, clk_q, done_q;

  // A CTRL write takes effect on the FSM in the same cycle it is presented.
  assign wr_ctrl  = wr_en_i && (wr_addr_i == NCO_ADDR_CTRL);
  assign ctrl_cur = wr_ctrl ? wr_data_i[NCO_CTRL_W-1:0] : ctrl;

  assign acc_int  = acc[AW-1:FRAC_W];
  assign acc_frac = acc[FRAC_W-1:0];

  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    quant_rnd = acc_int;
    if (acc_frac > FRAC_HALF)
      quant_rnd = acc_int + QW'(1);
    else if (acc_frac == FRAC_HALF)
      quant_rnd = acc_int + QW'(acc_int[0]);
    quant = (quant_rnd < QW'(2)) ? QW'(2) : quant_rnd;

    duty_ext = QW'(duty_act);
    high_cnt = quant >> 1;
    if (duty_act != '0)
      high_cnt = (duty_ext < quant - QW'(1)) ? duty_ext : quant - QW'(1);
  end

  assign boundary   = (state == NCO_RUN) && (cnt == quant - QW'(1));
  assign burst_eff  = (burst_sh == '0) ? BURST_W'(1) : burst_sh;
  assign burst_last = ctrl_cur[NCO_CTRL_BURST] && (bcnt >= burst_eff - BURST_W'(1));
  assign clk_int    = (state == NCO_RUN) && (cnt < high_cnt);

  // Floor at zero: periods below 2 cycles settle at quant=2 instead of wrapping the accumulator.
  assign acc_sum = {1'b0, acc} + (AW+1)'(per_act);
  assign acc_dec = {1'b0, quant, {FRAC_W{1'b0}}};
  assign acc_nxt = (acc_sum >= acc_dec) ? AW'(acc_sum - acc_dec) : '0;

  always_comb begin
    state_nxt = state;
    run_load  = 1'b0;
    done_nxt  = 1'b0;
    clr_en    = 1'b0;
    case (state)
      NCO_IDLE: begin
        if (wr_ctrl && wr_data_i[NCO_CTRL_EN]) begin
          if (wr_data_i[NCO_CTRL_WAIT_SYNC]) begin
            state_nxt = NCO_ARMED;
          end else begin
            state_nxt = NCO_RUN;
            run_load  = 1'b1;
          end
        end
      end
      NCO_ARMED: begin
        if (!ctrl_cur[NCO_CTRL_EN]) begin
          state_nxt = NCO_IDLE;
        end else if (start_i) begin
          state_nxt = NCO_RUN;
          run_load  = 1'b1;
        end
      end
      NCO_RUN: begin
        if (boundary) begin
          if (!ctrl_cur[NCO_CTRL_EN]) begin
            state_nxt = NCO_IDLE;
          end else if (burst_last) begin
            state_nxt = NCO_IDLE;
            done_nxt  = 1'b1;
            clr_en    = 1'b1;
          end
        end
      end
      default: state_nxt = NCO_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      state <= NCO_IDLE;
    else if (cke_i)
      state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      per_sh   <= '0;
      duty_sh  <= '0;
      burst_sh <= '0;
      ctrl     <= '0;
      acc      <= '0;
      per_act  <= '0;
      duty_act <= '0;
      cnt      <= '0;
      bcnt     <= '0;
      clk_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (cke_i) begin
      if (wr_en_i) begin
        case (wr_addr_i)
          NCO_ADDR_PERIOD: per_sh   <= wr_data_i;
          NCO_ADDR_DUTY:   duty_sh  <= wr_data_i[INT_W-1:0];
          NCO_ADDR_BURST:  burst_sh <= wr_data_i[BURST_W-1:0];
          default: ;
        endcase
      end
      ctrl <= ctrl_cur;
      if (clr_en)
        ctrl[NCO_CTRL_EN] <= 1'b0;

      // Active values reload only at a boundary, so a same-cycle shadow write lands one period later.
      if (run_load) begin
        acc      <= {1'b0, per_sh};
        per_act  <= per_sh;
        duty_act <= duty_sh;
        cnt      <= '0;
        bcnt     <= '0;
      end else if (boundary) begin
        acc      <= acc_nxt;
        per_act  <= per_sh;
        duty_act <= duty_sh;
        cnt      <= '0;
        bcnt     <= bcnt + BURST_W'(1);
      end else if (state == NCO_RUN) begin
        cnt <= cnt + QW'(1);
      end

      clk_q  <= clk_int;
      done_q <= done_nxt;
    end
  end

  assign clk_o  = clk_q;
  assign done_o = done_q;
  assign busy_o = (state != NCO_IDLE);

endmodule

// File: rtl/iob_nco_multi.sv
// N_CH-channel fractional-period NCO clock generator.
// Decodes the config target channel into per-channel write enables and fans out start_i.
module iob_nco_multi
  import iob_nco_multi_pkg::*;
#(
  parameter int  N_CH    = 4,
  parameter int  INT_W   = 16,
  parameter int  FRAC_W  = 16,
  parameter int  BURST_W = 16,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    rst_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [CH_W-1:0]         cfg_ch_i,
  input  logic [1:0]              cfg_addr_i,
  input  logic [INT_W+FRAC_W-1:0] cfg_wdata_i,
  input  logic                    start_i,
  output logic [N_CH-1:0]         clk_o,
  output logic [N_CH-1:0]         busy_o,
  output logic [N_CH-1:0]         done_o
);

  assign cfg_ready_o = 1'b1;

  // Channel indices at or above N_CH match no instance, so those writes fall on the floor.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic wr_en;
    assign wr_en = cfg_valid_i && (cfg_ch_i == CH_W'(g));

    iob_nco_ch #(
      .INT_W  (INT_W),
      .FRAC_W (FRAC_W),
      .BURST_W(BURST_W)
    ) u_ch (
      .clk_i    (clk_i),
      .cke_i    (cke_i),
      .rst_i    (rst_i),
      .wr_en_i  (wr_en),
      .wr_addr_i(cfg_addr_i),
      .wr_data_i(cfg_wdata_i),
      .start_i  (start_i),
      .clk_o    (clk_o[g]),
      .busy_o   (busy_o[g]),
      .done_o   (done_o[g])
    );
  end

endmodule

// File: tb/tb_iob_nco_multi.sv
// Self-checking bench for iob_nco_multi: table of period/duty vectors, hand-written
// burst/sync/update/reset/freeze sequences, and randomized runs against a period-list model.
module tb_iob_nco_multi;
  import iob_nco_multi_pkg::*;

  localparam int N_CH    = 3;
  localparam int INT_W   = 16;
  localparam int FRAC_W  = 16;
  localparam int BURST_W = 16;
  localparam int CH_W    = 2;
  localparam int DW      = INT_W + FRAC_W;

  logic            clk = 1'b0;
  logic            cke, rst, cfg_valid, cfg_ready, start;
  logic [CH_W-1:0] cfg_ch;
  logic [1:0]      cfg_addr;
  logic [DW-1:0]   cfg_wdata;
  logic [N_CH-1:0] gen_clk, busy, done;

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];

  typedef struct {
    int per_i;
    int per_f;
    int duty;
    int ncyc;
    int exp_rises;
    int exp_highs;
  } vec_t;
  vec_t vecs[8];

  iob_nco_multi #(
    .N_CH(N_CH), .INT_W(INT_W), .FRAC_W(FRAC_W), .BURST_W(BURST_W)
  ) dut (
    .clk_i      (clk),
    .cke_i      (cke),
    .rst_i      (rst),
    .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready),
    .cfg_ch_i   (cfg_ch),
    .cfg_addr_i (cfg_addr),
    .cfg_wdata_i(cfg_wdata),
    .start_i    (start),
    .clk_o      (gen_clk),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input logic [1:0] addr, input logic [DW-1:0] data);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_addr  = addr;
    cfg_wdata = data;
    tick();
    cfg_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] fx(input int i, input int f);
    return {i[15:0], f[15:0]};
  endfunction

  // Reference: list of quantised period lengths from the ideal fractional period, each
  // period emitted as its high cycles followed by its low cycles.
  task automatic build_wave(input longint per, input int duty, input int n);
    longint acc, ip, fr, q, h;
    exp_q.delete();
    acc = per;
    while (exp_q.size() < n) begin
      ip = acc >> 16;
      fr = acc & 64'hFFFF;
      if (fr > 32768)       q = ip + 1;
      else if (fr == 32768) q = ip + (ip % 2);
      else                  q = ip;
      if (q < 2) q = 2;
      if (duty == 0)          h = q / 2;
      else if (duty < q - 1)  h = duty;
      else                    h = q - 1;
      for (longint j = 0; j < q; j++) exp_q.push_back(j < h);
      acc = acc + per - q * 65536;
      if (acc < 0) acc = 0;
    end
  endtask

  initial begin
    int mism, highs, rises, dcount, dtick, busy_at_done, busy_before_done, last_tr, min_run, prev_s;
    int fr[N_CH];
    int rise_t[$];

    cke = 1'b1; rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;

    vecs[0] = '{4, 16'h0000, 0, 20, 5, 10};
    vecs[1] = '{2, 16'h8000, 1, 20, 8, 8};
    vecs[2] = '{1, 16'h0000, 0, 20, 10, 10};
    vecs[3] = '{5, 16'h0000, 9, 20, 4, 16};
    vecs[4] = '{3, 16'h4000, 0, 26, 8, 10};
    vecs[5] = '{6, 16'hC000, 3, 27, 4, 12};
    vecs[6] = '{7, 16'h0000, 0, 21, 3, 9};
    vecs[7] = '{4, 16'h8000, 0, 18, 4, 8};

    tick(); tick();
    check("reset_clk", gen_clk, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;
    check("cfg_ready", cfg_ready, 1);

    // Table-driven period/duty vectors.
    for (int i = 0; i < 8; i++) begin
      int ch;
      bit s, prev;
      ch = i % N_CH;
      do_reset();
      cfg_write(ch, NCO_ADDR_PERIOD, fx(vecs[i].per_i, vecs[i].per_f));
      cfg_write(ch, NCO_ADDR_DUTY, DW'(vecs[i].duty));
      cfg_write(ch, NCO_ADDR_CTRL, DW'(1));
      check($sformatf("vec%0d_first_low", i), gen_clk[ch], 0);
      rises = 0; highs = 0; prev = 1'b0;
      for (int k = 1; k <= vecs[i].ncyc; k++) begin
        tick();
        s = gen_clk[ch];
        if (k == 1) check($sformatf("vec%0d_first_high", i), s, 1);
        if (s && !prev) rises++;
        if (s) highs++;
        prev = s;
      end
      check($sformatf("vec%0d_rises", i), rises, vecs[i].exp_rises);
      check($sformatf("vec%0d_highs", i), highs, vecs[i].exp_highs);
    end

    // Burst of 3 periods on ch1.
    do_reset();
    cfg_write(1, NCO_ADDR_PERIOD, fx(5, 0));
    cfg_write(1, NCO_ADDR_DUTY, DW'(1));
    cfg_write(1, NCO_ADDR_BURST, DW'(3));
    cfg_write(1, NCO_ADDR_CTRL, DW'(3));
    check("burst_busy_start", busy[1], 1);
    rise_t.delete();
    prev_s = 0; dcount = 0; dtick = -1; busy_at_done = -1; busy_before_done = -1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (gen_clk[1] && prev_s == 0) rise_t.push_back(k);
      prev_s = gen_clk[1];
      if (k == 14) busy_before_done = busy[1];
      if (done[1]) begin
        dcount++;
        dtick = k;
        busy_at_done = busy[1];
      end
    end
    check("burst_rises", rise_t.size(), 3);
    if (rise_t.size() == 3) begin
      check("burst_gap1", rise_t[1] - rise_t[0], 5);
      check("burst_gap2", rise_t[2] - rise_t[1], 5);
    end
    check("burst_done_count", dcount, 1);
    check("burst_done_tick", dtick, 15);
    check("burst_busy_before_done", busy_before_done, 1);
    check("burst_busy_at_done", busy_at_done, 0);
    start = 1'b1;
    cfg_write(1, NCO_ADDR_PERIOD, fx(5, 0));
    start = 1'b0;
    tick(); tick();
    check("burst_stays_idle", busy[1], 0);

    // Start in the same cycle as the CTRL write is ignored; then synchronous release.
    do_reset();
    cfg_write(1, NCO_ADDR_PERIOD, fx(4, 0));
    cfg_write(0, NCO_ADDR_PERIOD, fx(6, 0));
    cfg_write(2, NCO_ADDR_PERIOD, fx(3, 0));
    start = 1'b1;
    cfg_write(1, NCO_ADDR_CTRL, DW'(5));
    start = 1'b0;
    check("armed_busy", busy[1], 1);
    highs = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (gen_clk[1]) highs++;
    end
    check("armed_ignores_same_cycle_start", highs, 0);
    cfg_write(0, NCO_ADDR_CTRL, DW'(5));
    cfg_write(2, NCO_ADDR_CTRL, DW'(5));
    highs = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      highs += int'($countones(gen_clk));
    end
    check("armed_quiet", highs, 0);
    check("armed_busy_all", busy, 3'b111);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < N_CH; c++) fr[c] = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      for (int c = 0; c < N_CH; c++) if (gen_clk[c] && fr[c] < 0) fr[c] = k;
    end
    check("sync_first_rise_ch0", fr[0], 1);
    check("sync_first_rise_ch1", fr[1], 1);
    check("sync_first_rise_ch2", fr[2], 1);

    // Clearing enable while ARMED.
    do_reset();
    cfg_write(0, NCO_ADDR_CTRL, DW'(5));
    check("armed_set", busy[0], 1);
    cfg_write(0, NCO_ADDR_CTRL, DW'(0));
    check("armed_clear_idle", busy[0], 0);

    // Period shadow update mid-period: current period keeps its length.
    do_reset();
    cfg_write(0, NCO_ADDR_PERIOD, fx(8, 0));
    cfg_write(0, NCO_ADDR_CTRL, DW'(1));
    rise_t.delete();
    prev_s = 0; last_tr = 0; min_run = 1000;
    for (int k = 1; k <= 40; k++) begin
      if (k == 4) begin
        cfg_valid = 1'b1; cfg_ch = '0; cfg_addr = NCO_ADDR_PERIOD; cfg_wdata = fx(4, 0);
      end
      tick();
      cfg_valid = 1'b0;
      if (int'(gen_clk[0]) != prev_s) begin
        if (last_tr > 0 && k - last_tr < min_run) min_run = k - last_tr;
        last_tr = k;
        if (gen_clk[0]) rise_t.push_back(k);
      end
      prev_s = int'(gen_clk[0]);
    end
    check("upd_rise_count_ok", rise_t.size() >= 6, 1);
    if (rise_t.size() >= 6) begin
      check("upd_first_period", rise_t[1] - rise_t[0], 8);
      check("upd_period_a", rise_t[3] - rise_t[2], 4);
      check("upd_period_b", rise_t[4] - rise_t[3], 4);
      check("upd_period_c", rise_t[5] - rise_t[4], 4);
    end
    check("upd_min_run_ge2", min_run >= 2, 1);

    // Reset mid-RUN (overrides cke), then a sub-2-cycle period.
    do_reset();
    cfg_write(0, NCO_ADDR_PERIOD, fx(4, 0));
    cfg_write(0, NCO_ADDR_CTRL, DW'(1));
    repeat (5) tick();
    rst = 1'b1; cke = 1'b0;
    tick();
    rst = 1'b0; cke = 1'b1;
    check("rst_clk", gen_clk, 0);
    check("rst_busy", busy, 0);
    cfg_write(0, NCO_ADDR_PERIOD, fx(1, 0));
    cfg_write(0, NCO_ADDR_CTRL, DW'(1));
    build_wave(64'h10000, 0, 8);
    mism = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (gen_clk[0] !== exp_q[k]) mism++;
    end
    check("per1_quant2_wave", mism, 0);

    // Clock-enable freeze: state held, config writes and start dropped.
    do_reset();
    cfg_write(0, NCO_ADDR_PERIOD, fx(4, 0));
    cfg_write(0, NCO_ADDR_CTRL, DW'(1));
    build_wave(64'h40000, 0, 20);
    mism = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (gen_clk[0] !== exp_q[k]) mism++;
    end
    check("cke_pre_wave", mism, 0);
    cke = 1'b0; start = 1'b1;
    cfg_valid = 1'b1; cfg_ch = '0; cfg_addr = NCO_ADDR_CTRL; cfg_wdata = '0;
    mism = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (gen_clk[0] !== exp_q[4] || busy[0] !== 1'b1) mism++;
    end
    check("cke_frozen", mism, 0);
    cke = 1'b1; start = 1'b0; cfg_valid = 1'b0;
    mism = 0;
    for (int k = 5; k < 13; k++) begin
      tick();
      if (gen_clk[0] !== exp_q[k]) mism++;
    end
    check("cke_resume_wave", mism, 0);

    // Out-of-range channel index.
    do_reset();
    cfg_write(3, NCO_ADDR_PERIOD, fx(4, 0));
    cfg_write(3, NCO_ADDR_CTRL, DW'(1));
    check("bad_ch_busy", busy, 0);
    repeat (3) tick();
    check("bad_ch_clk", gen_clk, 0);

    // Randomized single-channel runs against the period-list model.
    for (int it = 0; it < 12; it++) begin
      int ch, pi, pf, duty, other;
      ch   = int'($urandom_range(0, N_CH - 1));
      pi   = int'($urandom_range(2, 12));
      pf   = ($urandom_range(0, 3) == 0) ? 32768 : int'($urandom_range(0, 65535));
      duty = int'($urandom_range(0, 14));
      do_reset();
      cfg_write(ch, NCO_ADDR_PERIOD, fx(pi, pf));
      cfg_write(ch, NCO_ADDR_DUTY, DW'(duty));
      cfg_write(ch, NCO_ADDR_CTRL, DW'(1));
      build_wave(longint'(pi) * 65536 + longint'(pf), duty, 50);
      mism = 0; other = 0;
      for (int k = 0; k < 50; k++) begin
        tick();
        if (gen_clk[ch] !== exp_q[k]) mism++;
        for (int c = 0; c < N_CH; c++) if (c != ch && gen_clk[c] !== 1'b0) other++;
      end
      check($sformatf("rand%0d_ch%0d_p%0d.%0d_d%0d_wave", it, ch, pi, pf, duty), mism, 0);
      check($sformatf("rand%0d_others_low", it), other, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
